// File: rtl/grasspopper_arbiter_if.sv
// ----------------------------------------------------------------------------
// grasspopper_arbiter_if
//   Bundles the requester-side handshake, the result channel and the link to
//   the shared grasspopper core into one interface.
//
//   Signals
//     req_valid  [1:0]        per-requester block request
//     req_data   [1:0][127:0] per-requester plaintext block
//     req_ready  [1:0]        one-hot accept strobe
//     resp_valid [1:0]        one-hot result-available flag
//     resp_ready [1:0]        per-requester result acceptance
//     resp_data  [127:0]      result block
//     resp_err                timeout flag qualifying resp_data
//     core_start              one-cycle start pulse to the core
//     core_din   [127:0]      block handed to the core
//     core_dout  [127:0]      core result
//     core_busy               core busy flag
//
//   Modports
//     slave  : the arbiter
//     master : requesters plus the core (the environment around the arbiter)
// ----------------------------------------------------------------------------
interface grasspopper_arbiter_if;
    logic [1:0]        req_valid;
    logic [1:0][127:0] req_data;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [127:0]      resp_data;
    logic              resp_err;
    logic              core_start;
    logic [127:0]      core_din;
    logic [127:0]      core_dout;
    logic              core_busy;

    modport slave (
        input  req_valid, req_data, resp_ready, core_dout, core_busy,
        output req_ready, resp_valid, resp_data, resp_err, core_start, core_din
    );

    modport master (
        output req_valid, req_data, resp_ready, core_dout, core_busy,
        input  req_ready, resp_valid, resp_data, resp_err, core_start, core_din
    );
endinterface

// File: rtl/grasspopper_arbiter.sv
// ----------------------------------------------------------------------------
// grasspopper_arbiter
//   Shares one grasspopper block-cipher core between two requesters. One
//   transaction is in flight at a time: accept a block (IDLE), start the core
//   (ISSUE), wait for the core to finish (RUN), then hold the result until
//   the granted requester takes it (RESP). Ties are broken round-robin.
//
//   Ports
//     clk    sole clock, rising edge
//     reset  asynchronous, active-high; aborts any transaction in flight
//            (the core itself is not reset from here)
//     bus    grasspopper_arbiter_if.slave (request, response and core link)
//
//   Parameters
//     TIMEOUT_CYCLES  RUN cycles allowed before an abort (1..255); only
//                     acts when GP_ARB_TIMEOUT_EN is defined
//
//   Build option
//     GP_ARB_TIMEOUT_EN  adds an 8-bit RUN watchdog. On expiry the result is
//                        forced to zero and resp_err is raised with
//                        resp_valid. Without it RUN waits indefinitely and
//                        resp_err is tied low.
// ----------------------------------------------------------------------------
module grasspopper_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    grasspopper_arbiter_if.slave bus
);

    // The watchdog counter is 8 bits wide, so the limit has to fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         gnt;          // requester owning the current transaction
    logic         last_grant;   // requester served by the last completed handshake
    logic         pick;         // arbitration winner for this cycle
    logic         seen_busy;    // core has been seen busy during this RUN
    logic [127:0] blk;          // block latched at acceptance
    logic [127:0] resp_q;       // result held for the requester

    logic [1:0]   req_ready_c;
    logic [1:0]   resp_valid_c;
    logic         core_start_c;
    logic         accept;
    logic         complete;
    logic         handshake;
    logic         timeout;

    // Round-robin: a lone requester wins outright; on a tie the one that was
    // not served last time wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        pick = 1'b0;
        unique case (bus.req_valid)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

    // Completion needs a busy high-to-low sequence: a core that is still low
    // right after the start pulse has not begun yet.
    assign complete = (state == RUN) && seen_busy && !bus.core_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready_c  = 2'b00;
        resp_valid_c = 2'b00;
        core_start_c = 1'b0;
        accept       = 1'b0;
        handshake    = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated by reset so no accept strobe is shown while the
                // block is held in reset with requests pending.
                if (!reset && (bus.req_valid != 2'b00)) begin
                    accept            = 1'b1;
                    req_ready_c[pick] = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                core_start_c = 1'b1;
                state_nxt    = RUN;
            end
            RUN: begin
                if (complete || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid_c[gnt] = 1'b1;
                // Only the granted requester's ready bit can close the
                // transaction; the other bit is ignored.
                if (bus.resp_ready[gnt]) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;        // requester 0 wins the first tie
            seen_busy  <= 1'b0;
            blk        <= '0;
            resp_q     <= '0;
        end else begin
            if (accept) begin
                gnt <= pick;
                blk <= bus.req_data[pick];
            end

            if (state == ISSUE) begin
                seen_busy <= 1'b0;
            end else if ((state == RUN) && bus.core_busy) begin
                seen_busy <= 1'b1;
            end

            if (complete) begin
                resp_q <= bus.core_dout;
            end else if (timeout) begin
                resp_q <= '0;
            end

            if (handshake) begin
                last_grant <= gnt;
            end
        end
    end

`ifdef GP_ARB_TIMEOUT_EN
    logic [7:0] run_cnt;        // RUN cycles elapsed in this transaction
    logic       err_q;

    // A genuine completion in the same cycle takes priority over the abort.
    assign timeout = (state == RUN) && !complete &&
                     (run_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + 8'd1;
            end

            if (timeout) begin
                err_q <= 1'b1;
            end else if (handshake) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.resp_err = err_q;
`else
    assign timeout      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = resp_q;
    assign bus.core_start = core_start_c;
    assign bus.core_din   = blk;

endmodule

// File: tb/tb_grasspopper_arbiter.sv
// ----------------------------------------------------------------------------
// tb_grasspopper_arbiter
//   Directed bench for grasspopper_arbiter. A small core model answers each
//   start pulse with core_din ^ KEY after a programmable quiet gap and busy
//   length; expected results are written out as hand-computed constants.
//   Define GP_ARB_TIMEOUT_EN for both DUT and bench to cover the watchdog.
// ----------------------------------------------------------------------------
module tb_grasspopper_arbiter;

    localparam logic [127:0] KEY = {4{32'hA5A5_5A5A}};
    localparam logic [127:0] D0  = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
    localparam logic [127:0] D1  = {128{1'b1}};
    localparam logic [127:0] R0  = 128'hB487_691E_F0C3_2DD2_3C0F_E196_784B_A55A;
    localparam logic [127:0] R1  = {4{32'h5A5A_A5A5}};

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    grasspopper_arbiter_if bus ();

    grasspopper_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Core model: t counts cycles since the start pulse was sampled.
    int           pre_len  = 0;
    int           busy_len = 10;
    logic         active;
    int           t;
    logic [127:0] din_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            t      <= 0;
            din_q  <= '0;
        end else if (bus.core_start) begin
            active <= 1'b1;
            t      <= 1;
            din_q  <= bus.core_din;
        end else if (active) begin
            t <= t + 1;
        end
    end

    assign bus.core_busy = active && (t > pre_len) && (t <= pre_len + busy_len);
    assign bus.core_dout = (active && (t > pre_len + busy_len)) ? (din_q ^ KEY)
                                                                : 128'hDEAD_BEEF;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Runs one transaction end to end.
    task automatic txn(input string tag, input logic [1:0] valid,
                       input logic [1:0] valid_after, input int pre, input int len,
                       input int stall, input logic [1:0] exp_grant,
                       input logic [127:0] exp_din, input int exp_lat,
                       input logic [127:0] exp_resp, input logic exp_err);
        int n;
        int lat;
        pre_len        = pre;
        busy_len       = len;
        bus.req_valid  = valid;
        bus.resp_ready = 2'b00;
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req_ready"}, 128'(bus.req_ready), 128'(exp_grant));
        if (bus.req_ready == 2'b00) return;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = valid_after;
        check({tag, " core_start"}, 128'(bus.core_start), 128'(1'b1));
        check({tag, " core_din"}, bus.core_din, exp_din);
        check({tag, " req_ready pulse"}, 128'(bus.req_ready), 128'(2'b00));
        // Non-granted resp_ready must not complete anything.
        bus.resp_ready = ~exp_grant;
        lat = 0;
        while (bus.resp_valid == 2'b00 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " resp_valid"}, 128'(bus.resp_valid), 128'(exp_grant));
        check({tag, " resp_data"}, bus.resp_data, exp_resp);
        check({tag, " resp_err"}, 128'(bus.resp_err), 128'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall valid"}, 128'(bus.resp_valid), 128'(exp_grant));
            check({tag, " stall data"}, bus.resp_data, exp_resp);
            check({tag, " stall req_ready"}, 128'(bus.req_ready), 128'(2'b00));
        end
        bus.resp_ready = exp_grant;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 2'b00;
        check({tag, " resp_valid clr"}, 128'(bus.resp_valid), 128'(2'b00));
        check({tag, " resp_err clr"}, 128'(bus.resp_err), 128'(1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 128'(bus.req_ready), 128'(2'b00));
        check({tag, " resp_valid"}, 128'(bus.resp_valid), 128'(2'b00));
        check({tag, " resp_err"}, 128'(bus.resp_err), 128'(1'b0));
        check({tag, " core_start"}, 128'(bus.core_start), 128'(1'b0));
        check({tag, " core_din"}, bus.core_din, 128'(0));
        check({tag, " resp_data"}, bus.resp_data, 128'(0));
    endtask

    initial begin
        bus.req_valid   = 2'b11;
        bus.req_data[0] = D0;
        bus.req_data[1] = D1;
        bus.resp_ready  = 2'b00;
        #2 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single request, busy 10 cycles: result 2 + 10 cycles after acceptance.
        txn("single", 2'b01, 2'b00, 0, 10, 0, 2'b01, D0, 12, R0, 1'b0);

        // Tie after reset: grant order 0, 1, 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn("tie1", 2'b11, 2'b11, 0, 2, 0, 2'b01, D0, 4, R0, 1'b0);
        txn("tie2", 2'b11, 2'b11, 0, 2, 0, 2'b10, D1, 4, R1, 1'b0);
        txn("tie3", 2'b11, 2'b00, 0, 2, 0, 2'b01, D0, 4, R0, 1'b0);

        // Backpressure on requester 1 while requester 0 waits; requester 0
        // is accepted in the cycle right after the handshake.
        txn("bp", 2'b10, 2'b01, 0, 3, 5, 2'b10, D1, 5, R1, 1'b0);
        check("bp re-accept", 128'(bus.req_ready), 128'(2'b01));
        txn("bp_next", 2'b01, 2'b00, 0, 1, 0, 2'b01, D0, 3, R0, 1'b0);

        // Busy low for 3 cycles after ISSUE, high 4, then low.
        txn("glitch", 2'b01, 2'b00, 3, 4, 0, 2'b01, D0, 9, R0, 1'b0);

        // Reset 3 cycles into RUN; last_grant is 0 here, so only a reset
        // last_grant lets requester 0 win the following tie.
        pre_len       = 0;
        busy_len      = 20;
        bus.req_valid = 2'b01;
        #1;
        check("abort req_ready", 128'(bus.req_ready), 128'(2'b01));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        txn("post_abort", 2'b11, 2'b00, 0, 2, 0, 2'b01, D0, 4, R0, 1'b0);

`ifdef GP_ARB_TIMEOUT_EN
        // Core stuck busy: forced RESP after 8 RUN cycles with an error.
        txn("timeout", 2'b01, 2'b00, 0, 1000, 0, 2'b01, D0, 9, 128'(0), 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grasspopper_arbiter.md
GRASSPOPPER_ARBITER -- requirements
Module: grasspopper_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, maximum core busy cycles before abort; used only with GP_ARB_TIMEOUT_EN.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester block request; bit n belongs to requester n.
REQ-005 req_data  input  2x128  per-requester plaintext block; req_data[n] is held stable while req_valid[n]=1.
REQ-006 req_ready  output  2  one-hot accept strobe; the request is transferred when req_valid[n]&req_ready[n].
REQ-007 resp_valid  output  2  one-hot result-available flag.
REQ-008 resp_ready  input  2  per-requester result acceptance.
REQ-009 resp_data  output  128  result block, valid while any resp_valid bit is 1.
REQ-010 resp_err  output  1  timeout flag qualifying resp_data; tied 0 without GP_ARB_TIMEOUT_EN.
REQ-011 core_start  output  1  one-cycle start pulse to the shared grasspopper core.
REQ-012 core_din  output  128  block to the core data_i; valid during the core_start cycle.
REQ-013 core_dout  input  128  core data_o.
REQ-014 core_busy  input  1  core busy; high while the core computes.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, RUN and RESP, with exactly one transaction outstanding at a time.
REQ-016 IDLE: when any req_valid bit is set, grant one requester, pulse req_ready[g] for one cycle, latch req_data[g] and g, then go to ISSUE.
REQ-017 Arbitration is round-robin: a single requester wins outright; when both are valid, the requester other than last_grant wins.
REQ-018 ISSUE: core_start=1 and core_din=latched block for exactly one cycle, then go to RUN.
REQ-019 RUN: set seen_busy when core_busy=1; on the first cycle with core_busy=0 after seen_busy, capture core_dout into resp_data and go to RESP.
REQ-020 A core_busy that is already 0 in the cycle after ISSUE does not complete RUN; completion requires a busy high-to-low sequence.
REQ-021 RESP: assert resp_valid[g] with resp_data held stable until resp_ready[g]=1; on that cycle update last_grant=g, clear resp_valid and go to IDLE.
REQ-022 resp_ready on a non-granted bit, and resp_ready asserted before resp_valid, have no effect.
REQ-023 req_ready stays 0 outside IDLE; requests arriving then wait, and the earliest re-acceptance is the cycle after the RESP handshake.
REQ-024 Latency from acceptance to resp_valid = 2 + core busy duration cycles.
REQ-025 A req_valid that drops before acceptance is never granted and raises no error.

Reset
REQ-026 While reset=1: state=IDLE, last_grant=1 (requester 0 wins the first tie), seen_busy=0, req_ready=0, resp_valid=0, resp_err=0, core_start=0, core_din=0, resp_data=0.
REQ-027 Reset asserted mid-transaction aborts it immediately; the in-flight result is discarded, and the core is not reset by this block.

Configuration
REQ-028 With GP_ARB_TIMEOUT_EN defined, an 8-bit RUN-cycle counter is cleared on entry to RUN; reaching TIMEOUT_CYCLES forces RESP with resp_err=1 and resp_data=0.
REQ-029 With GP_ARB_TIMEOUT_EN defined, resp_err clears together with resp_valid.
REQ-030 Without GP_ARB_TIMEOUT_EN, no counter is present, RUN waits indefinitely, and resp_err=0.

Verification
REQ-031 Single request: req_valid=2'b01, data=128'h1122..; core busy 10 cycles -> req_ready=01 for 1 cycle, core_start 1 cycle later, resp_valid=01 with core_dout 12 cycles after acceptance.
REQ-032 Tie after reset: req_valid=2'b11 held for 3 transactions -> grant order 0,1,0.
REQ-033 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable; req_ready stays 0 until the handshake.
REQ-034 Busy glitch: core_busy=0 for 3 cycles after ISSUE, then high 4, then low -> completion only at the busy fall.
REQ-035 Reset asserted 3 cycles into RUN -> all outputs 0 asynchronously; next tie grants requester 0.
REQ-036 With GP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, core_busy stuck at 1 -> RESP after 8 RUN cycles, resp_err=1, resp_data=0.
